// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, product/accumulator types and saturation bounds for the MAC stage
package mac_pkg;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_CNT_W = 8;
  typedef logic signed [DEF_IN_W-1:0]  prod_t;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: signed accumulator plus sign-extended product, with overflow flag and optional clamp
import mac_pkg::*;
module mac_sat_add #(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] base,
  input  logic [IN_W-1:0]  prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] ext, raw;
  assign ext = {{(ACC_W-IN_W){prod[IN_W-1]}}, prod};
  assign raw = base + ext;
  assign ovf = (base[ACC_W-1] == prod[IN_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
  // Overflow can only go toward the shared operand sign, so base's sign picks the rail
  assign sum = (SAT && ovf) ? (base[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W))) : raw;
endmodule

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: final carry-propagate add of multiplier tree outputs, then grouped
// accumulation with count and sticky overflow, emitted per group over valid/ready
import mac_pkg::*;
module mac_accum_stage #(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SAT   = 1'b1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  sum_i,
  input  logic [IN_W-1:0]  carry_i,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  logic             s1_valid, s1_last, s1_adv, accept;
  logic [IN_W-1:0]  s1_prod;
  logic [ACC_W-1:0] acc, base, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_b, cnt_nx;
  logic             ovf, add_ovf, ovf_nx;
  assign s1_adv   = s1_valid && (!s1_last || !out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;
  assign base     = acc_clr ? '0 : acc;
  assign cnt_b    = acc_clr ? '0 : cnt;
  assign cnt_nx   = &cnt_b ? cnt_b : cnt_b + CNT_W'(1);
  assign ovf_nx   = (!acc_clr && ovf) || add_ovf;
  mac_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT(SAT)) u_add (
    .base(base),
    .prod(s1_prod),
    .sum (acc_nx),
    .ovf (add_ovf)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        s1_prod <= sum_i + carry_i;
        s1_last <= in_last;
      end
      s1_valid <= accept || (s1_valid && !s1_adv);
      if (s1_adv && s1_last) begin
        out_data  <= acc_nx;
        out_cnt   <= cnt_nx;
        out_ovf   <= ovf_nx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (s1_adv && !s1_last) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
      end else if (s1_adv || acc_clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule
